// File: rtl/x87_pkg.sv
// ---------------------------------------------------------------------------
// x87_pkg
// Shared definitions for the CPU-side x87 issue logic and the FPU decode:
// memory access size encodings, writeback kind codes, the issue state
// enumeration and a small step-counter helper.
// ---------------------------------------------------------------------------
package x87_pkg;

  // Memory access sizes as driven on rd_size / wr_size
  localparam logic [1:0] SZ_16 = 2'd0;
  localparam logic [1:0] SZ_32 = 2'd1;
  localparam logic [1:0] SZ_64 = 2'd2;

  // Writeback kinds reported by the FPU alongside fpu_wb_value
  localparam logic [2:0] WB_NONE    = 3'd0;
  localparam logic [2:0] WB_ST0     = 3'd1;
  localparam logic [2:0] WB_STATUS  = 3'd2;
  localparam logic [2:0] WB_CONTROL = 3'd3;
  localparam logic [2:0] WB_TAG     = 3'd4;

  // Issue sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4,
    ST_CMPL  = 3'd5
  } state_t;

  // Step counter advances while the FPU is busy and sticks at 15
  function automatic logic [3:0] stepNext(input logic [3:0] step, input logic busy);
    if (busy && (step != 4'hF)) begin
      return step + 4'd1;
    end
    return step;
  endfunction

endpackage

// File: rtl/x87_issue_watchdog.sv
// ---------------------------------------------------------------------------
// x87_issue_watchdog
// Cycle counter that bounds how long the issue logic waits for fpu_done.
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   i_clear  : zero the count (used when an FPU operation starts)
//   i_enable : count this cycle (high for every WAIT cycle)
//   o_expire : high while enabled and the count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module x87_issue_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_count;

  // The count stops at the expiry value so it can never wrap back below it
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/x87_issue.sv
// ---------------------------------------------------------------------------
// x87_issue
// CPU-side initiator of the x87 FPU command interface. Takes one ESC
// instruction at a time, fetches its memory operand when needed, starts the
// FPU, drives the step counter, captures writeback / memstore results,
// performs the store and returns a single completion to the pipeline.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_instr_* / o_instr_ready : instruction offer from execute (ready in IDLE)
//   o_rd_* / i_rd_*         : memory operand read (held until i_rd_ack)
//   o_wr_* / i_wr_ack       : memory store (held until i_wr_ack)
//   o_fpu_* / i_fpu_*       : FPU start/step/done/writeback protocol
//   i_memstore_*            : FPU store request captured during WAIT
//   o_mem_rdata32/64        : latched memory operand for the FPU
//   o_cmpl_*                : one-cycle completion plus held result fields
// ---------------------------------------------------------------------------
module x87_issue
  import x87_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [7:0]        i_instr_op1,
  input  logic [7:0]        i_instr_op2,
  input  logic              i_instr_op2_valid,
  input  logic              i_instr_mem_load,
  input  logic [1:0]        i_instr_load_size,
  input  logic [ADDR_W-1:0] i_instr_addr,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [1:0]        o_rd_size,
  input  logic              i_rd_ack,
  input  logic [63:0]       i_rd_data,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [1:0]        o_wr_size,
  output logic [63:0]       o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_fpu_start,
  output logic [7:0]        o_fpu_op1,
  output logic [7:0]        o_fpu_op2,
  output logic              o_fpu_op2_valid,
  output logic [3:0]        o_fpu_step,
  output logic [31:0]       o_mem_rdata32,
  output logic [63:0]       o_mem_rdata64,
  input  logic              i_fpu_busy,
  input  logic              i_fpu_done,
  input  logic              i_fpu_wb_valid,
  input  logic [2:0]        i_fpu_wb_kind,
  input  logic [15:0]       i_fpu_wb_value,
  input  logic              i_memstore_valid,
  input  logic [1:0]        i_memstore_size,
  input  logic [63:0]       i_memstore_data64,
  output logic              o_cmpl_valid,
  output logic              o_cmpl_wb_valid,
  output logic [2:0]        o_cmpl_wb_kind,
  output logic [15:0]       o_cmpl_wb_value,
  output logic              o_cmpl_timeout
);

  state_t r_state;
  state_t w_next;

  logic              r_outOfReset;
  logic [7:0]        r_op1;
  logic [7:0]        r_op2;
  logic              r_op2Valid;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_loadSize;
  logic [63:0]       r_rdata64;
  logic [3:0]        r_step;
  logic              r_wbFlag;
  logic [2:0]        r_wbKind;
  logic [15:0]       r_wbValue;
  logic              r_stFlag;
  logic [1:0]        r_stSize;
  logic [63:0]       r_stData;
  logic              r_timeout;

  logic w_idleReady;
  logic w_accept;
  logic w_wdClear;
  logic w_wdEnable;
  logic w_expire;

  // Ready is held off for the first cycle after reset so every output reads
  // 0 while reset is applied and ready only rises once it has been released
  assign w_idleReady = (r_state == ST_IDLE) && r_outOfReset;
  assign w_accept    = i_instr_valid && w_idleReady;

  x87_issue_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_wdClear),
    .i_enable (w_wdEnable),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe outputs. fpu_done beats a same-cycle watchdog
  // expiry, and a memstore seen in the done cycle still forces a STORE.
  always_comb begin
    w_next        = r_state;
    o_instr_ready = w_idleReady;
    o_rd_req      = 1'b0;
    o_wr_req      = 1'b0;
    o_fpu_start   = 1'b0;
    o_cmpl_valid  = 1'b0;
    w_wdClear     = 1'b0;
    w_wdEnable    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = i_instr_mem_load ? ST_LOAD : ST_START;
        end
      end
      ST_LOAD: begin
        o_rd_req = 1'b1;
        if (i_rd_ack) begin
          w_next = ST_START;
        end
      end
      ST_START: begin
        o_fpu_start = 1'b1;
        w_wdClear   = 1'b1;
        w_next      = ST_WAIT;
      end
      ST_WAIT: begin
        w_wdEnable = 1'b1;
        if (i_fpu_done) begin
          w_next = (r_stFlag || i_memstore_valid) ? ST_STORE : ST_CMPL;
        end else if (w_expire) begin
          w_next = ST_CMPL;
        end
      end
      ST_STORE: begin
        o_wr_req = 1'b1;
        if (i_wr_ack) begin
          w_next = ST_CMPL;
        end
      end
      ST_CMPL: begin
        o_cmpl_valid = 1'b1;
        w_next       = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Instruction latches, operand capture, step counter and result capture.
  // Result flags are cleared on accept so the previous completion's fields
  // stay visible until a new instruction is taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outOfReset <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_op2Valid   <= 1'b0;
      r_addr       <= '0;
      r_loadSize   <= SZ_16;
      r_rdata64    <= '0;
      r_step       <= '0;
      r_wbFlag     <= 1'b0;
      r_wbKind     <= WB_NONE;
      r_wbValue    <= '0;
      r_stFlag     <= 1'b0;
      r_stSize     <= SZ_16;
      r_stData     <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_outOfReset <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op1      <= i_instr_op1;
            r_op2      <= i_instr_op2;
            r_op2Valid <= i_instr_op2_valid;
            r_addr     <= i_instr_addr;
            r_loadSize <= i_instr_load_size;
            r_step     <= '0;
            r_wbFlag   <= 1'b0;
            r_stFlag   <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (i_rd_ack) begin
            r_rdata64 <= i_rd_data;
          end
        end
        ST_START: begin
          r_step   <= '0;
          r_wbFlag <= 1'b0;
          r_stFlag <= 1'b0;
        end
        ST_WAIT: begin
          r_step <= stepNext(r_step, i_fpu_busy);
          if (i_fpu_wb_valid) begin
            r_wbFlag  <= 1'b1;
            r_wbKind  <= i_fpu_wb_kind;
            r_wbValue <= i_fpu_wb_value;
          end
          if (i_memstore_valid) begin
            r_stFlag <= 1'b1;
            r_stSize <= i_memstore_size;
            r_stData <= i_memstore_data64;
          end
          if (w_expire && !i_fpu_done) begin
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rd_addr       = (r_state == ST_LOAD)  ? r_addr     : '0;
  assign o_rd_size       = (r_state == ST_LOAD)  ? r_loadSize : SZ_16;
  assign o_wr_addr       = (r_state == ST_STORE) ? r_addr     : '0;
  assign o_wr_size       = (r_state == ST_STORE) ? r_stSize   : SZ_16;
  assign o_wr_data       = (r_state == ST_STORE) ? r_stData   : '0;
  assign o_fpu_op1       = r_op1;
  assign o_fpu_op2       = r_op2;
  assign o_fpu_op2_valid = r_op2Valid;
  assign o_fpu_step      = r_step;
  assign o_mem_rdata64   = r_rdata64;
  assign o_mem_rdata32   = r_rdata64[31:0];
  assign o_cmpl_wb_valid = r_wbFlag;
  assign o_cmpl_wb_kind  = r_wbKind;
  assign o_cmpl_wb_value = r_wbValue;
  assign o_cmpl_timeout  = r_timeout;

endmodule

// File: tb/tb_x87_issue.sv
// ---------------------------------------------------------------------------
// tb_x87_issue
// Directed bench for x87_issue. Two instances share the memory/FPU stimulus:
// the main one with a long watchdog and a second one with TIMEOUT=16 that
// only ever receives the timeout instruction. Expected completions are
// queued when an instruction is offered and retired by a monitor process.
// ---------------------------------------------------------------------------
module tb_x87_issue;

  typedef struct {
    logic        wbValid;
    logic [2:0]  kind;
    logic [15:0] value;
    logic        timeout;
  } cmplExp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        instr_valid, instr_valid_t;
  logic [7:0]  instr_op1, instr_op2;
  logic        instr_op2_valid, instr_mem_load;
  logic [1:0]  instr_load_size;
  logic [31:0] instr_addr;
  logic        rd_ack, wr_ack;
  logic [63:0] rd_data;
  logic        fpu_busy, fpu_done, fpu_wb_valid;
  logic [2:0]  fpu_wb_kind;
  logic [15:0] fpu_wb_value;
  logic        memstore_valid;
  logic [1:0]  memstore_size;
  logic [63:0] memstore_data64;

  // Main instance outputs
  logic        instr_ready, rd_req, wr_req, fpu_start, fpu_op2_valid;
  logic [31:0] rd_addr, wr_addr, mem_rdata32;
  logic [1:0]  rd_size, wr_size;
  logic [63:0] wr_data, mem_rdata64;
  logic [7:0]  fpu_op1, fpu_op2;
  logic [3:0]  fpu_step;
  logic        cmpl_valid, cmpl_wb_valid, cmpl_timeout;
  logic [2:0]  cmpl_wb_kind;
  logic [15:0] cmpl_wb_value;

  // Short-watchdog instance outputs
  logic        instr_ready_t, rd_req_t, wr_req_t, fpu_start_t, fpu_op2_valid_t;
  logic [31:0] rd_addr_t, wr_addr_t, mem_rdata32_t;
  logic [1:0]  rd_size_t, wr_size_t;
  logic [63:0] wr_data_t, mem_rdata64_t;
  logic [7:0]  fpu_op1_t, fpu_op2_t;
  logic [3:0]  fpu_step_t;
  logic        cmpl_valid_t, cmpl_wb_valid_t, cmpl_timeout_t;
  logic [2:0]  cmpl_wb_kind_t;
  logic [15:0] cmpl_wb_value_t;

  x87_issue #(.TIMEOUT(64), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr_op1(instr_op1), .i_instr_op2(instr_op2),
    .i_instr_op2_valid(instr_op2_valid), .i_instr_mem_load(instr_mem_load),
    .i_instr_load_size(instr_load_size), .i_instr_addr(instr_addr),
    .o_rd_req(rd_req), .o_rd_addr(rd_addr), .o_rd_size(rd_size),
    .i_rd_ack(rd_ack), .i_rd_data(rd_data),
    .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_size(wr_size),
    .o_wr_data(wr_data), .i_wr_ack(wr_ack),
    .o_fpu_start(fpu_start), .o_fpu_op1(fpu_op1), .o_fpu_op2(fpu_op2),
    .o_fpu_op2_valid(fpu_op2_valid), .o_fpu_step(fpu_step),
    .o_mem_rdata32(mem_rdata32), .o_mem_rdata64(mem_rdata64),
    .i_fpu_busy(fpu_busy), .i_fpu_done(fpu_done),
    .i_fpu_wb_valid(fpu_wb_valid), .i_fpu_wb_kind(fpu_wb_kind),
    .i_fpu_wb_value(fpu_wb_value),
    .i_memstore_valid(memstore_valid), .i_memstore_size(memstore_size),
    .i_memstore_data64(memstore_data64),
    .o_cmpl_valid(cmpl_valid), .o_cmpl_wb_valid(cmpl_wb_valid),
    .o_cmpl_wb_kind(cmpl_wb_kind), .o_cmpl_wb_value(cmpl_wb_value),
    .o_cmpl_timeout(cmpl_timeout)
  );

  x87_issue #(.TIMEOUT(16), .ADDR_W(32)) dutT (
    .i_clk(clk), .i_rst(rst),
    .i_instr_valid(instr_valid_t), .o_instr_ready(instr_ready_t),
    .i_instr_op1(instr_op1), .i_instr_op2(instr_op2),
    .i_instr_op2_valid(instr_op2_valid), .i_instr_mem_load(instr_mem_load),
    .i_instr_load_size(instr_load_size), .i_instr_addr(instr_addr),
    .o_rd_req(rd_req_t), .o_rd_addr(rd_addr_t), .o_rd_size(rd_size_t),
    .i_rd_ack(rd_ack), .i_rd_data(rd_data),
    .o_wr_req(wr_req_t), .o_wr_addr(wr_addr_t), .o_wr_size(wr_size_t),
    .o_wr_data(wr_data_t), .i_wr_ack(wr_ack),
    .o_fpu_start(fpu_start_t), .o_fpu_op1(fpu_op1_t), .o_fpu_op2(fpu_op2_t),
    .o_fpu_op2_valid(fpu_op2_valid_t), .o_fpu_step(fpu_step_t),
    .o_mem_rdata32(mem_rdata32_t), .o_mem_rdata64(mem_rdata64_t),
    .i_fpu_busy(fpu_busy), .i_fpu_done(fpu_done),
    .i_fpu_wb_valid(fpu_wb_valid), .i_fpu_wb_kind(fpu_wb_kind),
    .i_fpu_wb_value(fpu_wb_value),
    .i_memstore_valid(memstore_valid), .i_memstore_size(memstore_size),
    .i_memstore_data64(memstore_data64),
    .o_cmpl_valid(cmpl_valid_t), .o_cmpl_wb_valid(cmpl_wb_valid_t),
    .o_cmpl_wb_kind(cmpl_wb_kind_t), .o_cmpl_wb_value(cmpl_wb_value_t),
    .o_cmpl_timeout(cmpl_timeout_t)
  );

  int nChecks = 0;
  int errors  = 0;
  int rdCycles = 0;
  int wrCycles = 0;
  int wrCyclesT = 0;
  cmplExp_t expQ[$];
  cmplExp_t expQT[$];

  // Step to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compareCmpl(input string tag, input cmplExp_t e, input logic wbv,
                             input logic [2:0] kind, input logic [15:0] value, input logic tmo);
    checkOutput({tag, ".wbValid"}, 64'(wbv), 64'(e.wbValid));
    checkOutput({tag, ".timeout"}, 64'(tmo), 64'(e.timeout));
    if (e.wbValid) begin
      checkOutput({tag, ".kind"},  64'(kind),  64'(e.kind));
      checkOutput({tag, ".value"}, 64'(value), 64'(e.value));
    end
  endtask

  // Monitor: counts request cycles and retires completions against the queues
  task automatic monitorLoop();
    cmplExp_t e;
    forever begin
      @(negedge clk);
      if (rd_req)   rdCycles++;
      if (wr_req)   wrCycles++;
      if (wr_req_t) wrCyclesT++;
      if (cmpl_valid) begin
        if (expQ.size() == 0) begin
          nChecks++; errors++;
          $display("[TB] FAIL unexpectedCmpl: got cmpl_valid=1 expected none");
        end else begin
          e = expQ.pop_front();
          compareCmpl("cmpl", e, cmpl_wb_valid, cmpl_wb_kind, cmpl_wb_value, cmpl_timeout);
        end
      end
      if (cmpl_valid_t) begin
        if (expQT.size() == 0) begin
          nChecks++; errors++;
          $display("[TB] FAIL unexpectedCmplT: got cmpl_valid=1 expected none");
        end else begin
          e = expQT.pop_front();
          compareCmpl("cmplT", e, cmpl_wb_valid_t, cmpl_wb_kind_t, cmpl_wb_value_t, cmpl_timeout_t);
        end
      end
    end
  endtask

  // Offer one instruction for one edge; returns in START or LOAD
  task automatic applyStimulus(input bit toT, input logic [7:0] op1, input logic [7:0] op2,
                               input logic memLoad, input logic [1:0] size, input logic [31:0] addr);
    instr_op1 = op1; instr_op2 = op2; instr_op2_valid = 1'b1;
    instr_mem_load = memLoad; instr_load_size = size; instr_addr = addr;
    if (toT) instr_valid_t = 1'b1; else instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; instr_valid_t = 1'b0;
  endtask

  task automatic clearFpu();
    fpu_done = 1'b0; fpu_wb_valid = 1'b0; memstore_valid = 1'b0;
  endtask

  initial begin
    int rdBase;
    int wrBase;
    rst = 1'b1; instr_valid = 1'b0; instr_valid_t = 1'b0;
    instr_op1 = '0; instr_op2 = '0; instr_op2_valid = 1'b0; instr_mem_load = 1'b0;
    instr_load_size = '0; instr_addr = '0; rd_ack = 1'b0; wr_ack = 1'b0; rd_data = '0;
    fpu_busy = 1'b0; fpu_done = 1'b0; fpu_wb_valid = 1'b0; fpu_wb_kind = '0;
    fpu_wb_value = '0; memstore_valid = 1'b0; memstore_size = '0; memstore_data64 = '0;
    fork
      monitorLoop();
    join_none

    // Reset state
    repeat (3) tick();
    checkOutput("rstReady", 64'(instr_ready), 64'd0);
    checkOutput("rstRdReq", 64'(rd_req), 64'd0);
    checkOutput("rstStep", 64'(fpu_step), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("readyAfterRst", 64'(instr_ready), 64'd1);
    checkOutput("readyAfterRstT", 64'(instr_ready_t), 64'd1);

    // Register op: done 3 cycles after start with a writeback
    rdBase = rdCycles; wrBase = wrCycles;
    expQ.push_back('{wbValid: 1'b1, kind: 3'd1, value: 16'h1234, timeout: 1'b0});
    applyStimulus(1'b0, 8'hD9, 8'hC0, 1'b0, 2'd0, 32'h0);
    checkOutput("regStart", 64'(fpu_start), 64'd1);
    checkOutput("regOp1", 64'(fpu_op1), 64'hD9);
    checkOutput("regOp2", 64'(fpu_op2), 64'hC0);
    checkOutput("regOp2v", 64'(fpu_op2_valid), 64'd1);
    checkOutput("regReadyBusy", 64'(instr_ready), 64'd0);
    tick();
    checkOutput("regStartPulse", 64'(fpu_start), 64'd0);
    tick(); tick();
    fpu_done = 1'b1; fpu_wb_valid = 1'b1; fpu_wb_kind = 3'd1; fpu_wb_value = 16'h1234;
    tick();
    clearFpu();
    checkOutput("regCmplAt", 64'(cmpl_valid), 64'd1);
    tick();
    checkOutput("regReadyAgain", 64'(instr_ready), 64'd1);
    checkOutput("regHoldValue", 64'(cmpl_wb_value), 64'h1234);
    checkOutput("regNoRd", 64'(rdCycles - rdBase), 64'd0);
    checkOutput("regNoWr", 64'(wrCycles - wrBase), 64'd0);

    // Load op: rd_ack arrives in the fifth request cycle
    rdBase = rdCycles;
    expQ.push_back('{wbValid: 1'b0, kind: 3'd0, value: 16'h0, timeout: 1'b0});
    applyStimulus(1'b0, 8'hDD, 8'h06, 1'b1, 2'd2, 32'h1000);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("ldRdReq%0d", i), 64'(rd_req), 64'd1);
      checkOutput($sformatf("ldRdAddr%0d", i), 64'(rd_addr), 64'h1000);
      checkOutput($sformatf("ldRdSize%0d", i), 64'(rd_size), 64'd2);
      if (i == 5) begin
        rd_ack = 1'b1; rd_data = 64'h400921FB54442D18;
      end
      tick();
    end
    rd_ack = 1'b0; rd_data = '0;
    checkOutput("ldStartAfterAck", 64'(fpu_start), 64'd1);
    checkOutput("ldRdReqDrop", 64'(rd_req), 64'd0);
    checkOutput("ldRdata64", mem_rdata64, 64'h400921FB54442D18);
    checkOutput("ldRdata32", 64'(mem_rdata32), 64'h54442D18);
    checkOutput("ldRdCycles", 64'(rdCycles - rdBase), 64'd5);
    tick(); tick();
    fpu_done = 1'b1;
    tick();
    clearFpu();
    tick();
    checkOutput("ldRdataHeld", mem_rdata64, 64'h400921FB54442D18);

    // Store op: two writebacks (last wins), memstore with done, wr_ack late
    wrBase = wrCycles;
    expQ.push_back('{wbValid: 1'b1, kind: 3'd3, value: 16'h5678, timeout: 1'b0});
    applyStimulus(1'b0, 8'hD9, 8'h1D, 1'b0, 2'd0, 32'h2000);
    tick();
    fpu_wb_valid = 1'b1; fpu_wb_kind = 3'd2; fpu_wb_value = 16'h1111;
    tick();
    fpu_wb_kind = 3'd3; fpu_wb_value = 16'h5678;
    fpu_done = 1'b1; memstore_valid = 1'b1; memstore_size = 2'd1; memstore_data64 = 64'h3F800000;
    tick();
    clearFpu();
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("stWrReq%0d", i), 64'(wr_req), 64'd1);
      checkOutput($sformatf("stWrAddr%0d", i), 64'(wr_addr), 64'h2000);
      checkOutput($sformatf("stWrSize%0d", i), 64'(wr_size), 64'd1);
      checkOutput($sformatf("stWrData%0d", i), wr_data, 64'h3F800000);
      checkOutput($sformatf("stNoCmpl%0d", i), 64'(cmpl_valid), 64'd0);
      if (i == 3) wr_ack = 1'b1;
      tick();
    end
    wr_ack = 1'b0;
    checkOutput("stCmplAfterAck", 64'(cmpl_valid), 64'd1);
    checkOutput("stWrReqDrop", 64'(wr_req), 64'd0);
    checkOutput("stWrCycles", 64'(wrCycles - wrBase), 64'd3);
    tick();

    // Step counter: busy for 20 WAIT cycles, saturates at 15
    expQ.push_back('{wbValid: 1'b0, kind: 3'd0, value: 16'h0, timeout: 1'b0});
    applyStimulus(1'b0, 8'hD8, 8'hC1, 1'b0, 2'd0, 32'h0);
    checkOutput("stepAtStart", 64'(fpu_step), 64'd0);
    fpu_busy = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("step%0d", k), 64'(fpu_step), 64'((k - 1 > 15) ? 15 : k - 1));
    end
    fpu_busy = 1'b0;
    tick();
    checkOutput("stepSat", 64'(fpu_step), 64'd15);
    tick();
    checkOutput("stepHold", 64'(fpu_step), 64'd15);
    fpu_done = 1'b1;
    tick();
    clearFpu();
    tick();

    // Timeout on the TIMEOUT=16 instance, memstore seen but store suppressed
    expQT.push_back('{wbValid: 1'b0, kind: 3'd0, value: 16'h0, timeout: 1'b1});
    applyStimulus(1'b1, 8'hDD, 8'h1E, 1'b0, 2'd0, 32'h3000);
    checkOutput("tmoStart", 64'(fpu_start_t), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3) begin
        memstore_valid = 1'b1; memstore_size = 2'd2; memstore_data64 = 64'hDEADBEEF;
      end else begin
        memstore_valid = 1'b0;
      end
    end
    tick();
    checkOutput("tmoCmplAt", 64'(cmpl_valid_t), 64'd1);
    checkOutput("tmoNoWrReq", 64'(wr_req_t), 64'd0);
    tick();
    checkOutput("tmoReady", 64'(instr_ready_t), 64'd1);
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    tick();
    checkOutput("tmoLateDoneReady", 64'(instr_ready_t), 64'd1);
    checkOutput("tmoNoWrCycles", 64'(wrCyclesT), 64'd0);

    // Reset mid-LOAD
    applyStimulus(1'b0, 8'hDD, 8'h06, 1'b1, 2'd2, 32'h4000);
    tick();
    checkOutput("rlRdReq", 64'(rd_req), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rlRdReqDrop", 64'(rd_req), 64'd0);
    checkOutput("rlNoCmpl", 64'(cmpl_valid), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("rlReady", 64'(instr_ready), 64'd1);

    // Reset mid-STORE, followed by a late fpu_done that must be ignored
    applyStimulus(1'b0, 8'hD9, 8'h1D, 1'b0, 2'd0, 32'h5000);
    tick();
    fpu_done = 1'b1; memstore_valid = 1'b1; memstore_size = 2'd1; memstore_data64 = 64'h1;
    tick();
    clearFpu();
    checkOutput("rsWrReq", 64'(wr_req), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rsWrReqDrop", 64'(wr_req), 64'd0);
    checkOutput("rsNoCmpl", 64'(cmpl_valid), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("rsReady", 64'(instr_ready), 64'd1);
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    repeat (3) tick();
    checkOutput("rsStillIdle", 64'(instr_ready), 64'd1);

    checkOutput("pendingCmpl", 64'(expQ.size()), 64'd0);
    checkOutput("pendingCmplT", 64'(expQT.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, nChecks);
    $finish;
  end

endmodule
